// File: rtl/fp_pkg.sv
// ============================================================================
// fp_pkg : shared FP constants, flag indices and divider state encoding
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fp_pkg;

  localparam int          FP_EXP_BIAS = 127;
  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF  = 32'h7F800000;

  // Bit positions inside the 4-bit flags word
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_DIV_ZERO  = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } fpdiv_state_t;

  function automatic logic [31:0] fp_signed_inf(input logic s);
    return {s, FP_POS_INF[30:0]};
  endfunction

  function automatic logic [31:0] fp_signed_zero(input logic s);
    return {s, 31'd0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_div_seq_if.sv
// ============================================================================
// fp_div_seq_if : operand/result valid-ready handshake for fp_div_seq
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fp_div_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

`default_nettype wire

// File: rtl/fp_div_mant_core.sv
// ============================================================================
// fp_div_mant_core : iterative restoring divider, q = floor(ma*2^25/mb)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fp_div_mant_core #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] ma,
  input  logic [23:0] mb,
  output logic [25:0] q,
  output logic [24:0] r,
  output logic        done
);

  localparam int ITERS = 26 / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS + 1);

  logic [24:0]      rem;
  logic [23:0]      div;
  logic [25:0]      quo;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  logic [24:0] t_rem;
  logic [25:0] t_quo;
  logic [23:0] t_div;
  logic        ge;
  logic [23:0] diff;

  // The start cycle already retires its quotient bits so the loop needs no
  // separate load cycle. Remainder starts at ma (< 2*mb) which yields q[25].
  always_comb begin
    t_rem = start ? {1'b0, ma} : rem;
    t_quo = start ? 26'd0 : quo;
    t_div = start ? mb : div;
    ge    = 1'b0;
    diff  = 24'd0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      ge    = (t_rem >= {1'b0, t_div});
      diff  = ge ? 24'(t_rem - {1'b0, t_div}) : t_rem[23:0];
      t_rem = {diff, 1'b0};
      t_quo = {t_quo[24:0], ge};
    end
  end

  assign done = busy && (cnt == CNT_W'(ITERS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem  <= '0;
      div  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= t_rem;
      quo  <= t_quo;
      div  <= mb;
      cnt  <= CNT_W'(1);
      busy <= 1'b1;
    end else if (busy) begin
      rem <= t_rem;
      quo <= t_quo;
      cnt <= cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

  // rem holds the remainder pre-shifted by one
  logic unused_rem_lsb;
  assign unused_rem_lsb = rem[0];

  assign q = quo;
  assign r = {1'b0, rem[24:1]};

endmodule

`default_nettype wire

// File: rtl/fp_div_seq.sv
// ============================================================================
// fp_div_seq : sequential IEEE-754 single divider with valid/ready handshake
// Optional macro FPDIV_ROUND_RNE_EN selects round-to-nearest-even (else truncate)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fp_div_seq
  import fp_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          reset,
  fp_div_seq_if.slave   bus
);

  fpdiv_state_t state, next_state;

  logic               sign;
  logic signed [9:0]  exp_q;
  logic [31:0]        result_q;
  logic [3:0]         flags_q;

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  assign {sa, ea, fa} = bus.a;
  assign {sb, eb, fb} = bus.b;

  logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, s_res;
  assign zero_a = (ea == 8'h00);
  assign zero_b = (eb == 8'h00);
  assign inf_a  = (ea == 8'hFF) && (fa == 23'd0);
  assign inf_b  = (eb == 8'hFF) && (fb == 23'd0);
  assign nan_a  = (ea == 8'hFF) && (fa != 23'd0);
  assign nan_b  = (eb == 8'hFF) && (fb != 23'd0);
  assign s_res  = sa ^ sb;

  logic accept;
  assign accept = bus.in_valid && (state == IDLE);

  logic        special;
  logic [31:0] spec_result;
  logic [3:0]  spec_flags;

  always_comb begin
    special     = 1'b1;
    spec_result = 32'd0;
    spec_flags  = 4'd0;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      spec_result              = FP_QNAN;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (zero_b && !inf_a) begin
      spec_result               = fp_signed_inf(s_res);
      spec_flags[FLAG_DIV_ZERO] = 1'b1;
    end else if (inf_a) begin
      spec_result = fp_signed_inf(s_res);
    end else if (zero_a || inf_b) begin
      spec_result = fp_signed_zero(s_res);
    end else begin
      special = 1'b0;
    end
  end

  logic signed [9:0] e_calc;
  assign e_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(10'(FP_EXP_BIAS));

  logic        core_start, core_done;
  logic [25:0] q;
  logic [24:0] r;
  assign core_start = accept && !special;

  fp_div_mant_core #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .start (core_start),
    .ma    ({1'b1, fa}),
    .mb    ({1'b1, fb}),
    .q     (q),
    .r     (r),
    .done  (core_done)
  );

  logic [23:0]       mant, mant_fin;
  logic [24:0]       mant_rnd;
  logic signed [9:0] e_norm, e_fin;
  logic              round_inc;
  logic [31:0]       norm_result;
  logic [3:0]        norm_flags;
`ifdef FPDIV_ROUND_RNE_EN
  logic guard, sticky;
`endif

  always_comb begin
    mant      = q[25] ? q[25:2] : q[24:1];
    e_norm    = q[25] ? exp_q : exp_q - 10'sd1;
    round_inc = 1'b0;
`ifdef FPDIV_ROUND_RNE_EN
    guard     = q[25] ? q[1] : q[0];
    sticky    = (q[25] & q[0]) | (r != 25'd0);
    round_inc = guard & (sticky | mant[0]);
`endif
    mant_rnd = {1'b0, mant} + {24'd0, round_inc};
    if (mant_rnd[24]) begin
      mant_fin = mant_rnd[24:1];
      e_fin    = e_norm + 10'sd1;
    end else begin
      mant_fin = mant_rnd[23:0];
      e_fin    = e_norm;
    end
    norm_flags  = 4'd0;
    norm_result = {sign, e_fin[7:0], mant_fin[22:0]};
    if (e_fin >= 10'sd255) begin
      norm_result               = fp_signed_inf(sign);
      norm_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      norm_result                = fp_signed_zero(sign);
      norm_flags[FLAG_UNDERFLOW] = 1'b1;
    end
  end

  // Hidden bit of the final mantissa is implicit; truncation ignores q[0] and r
  logic unused_bits;
`ifdef FPDIV_ROUND_RNE_EN
  assign unused_bits = mant_fin[23];
`else
  assign unused_bits = ^{mant_fin[23], q[0], r};
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = special ? DONE : DIVIDE;
      DIVIDE:  if (core_done) next_state = NORM;
      NORM:    next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sign     <= 1'b0;
      exp_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        sign  <= s_res;
        exp_q <= e_calc;
        if (special) begin
          result_q <= spec_result;
          flags_q  <= spec_flags;
        end
      end
      if (state == NORM) begin
        result_q <= norm_result;
        flags_q  <= norm_flags;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_div_seq.sv
// ============================================================================
// tb_fp_div_seq : directed table, corner sequences and random ops vs a model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fp_div_seq;

  localparam int BPC      = 1;
  localparam int NORM_LAT = 26 / BPC + 1;
`ifdef FPDIV_ROUND_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  fp_div_seq_if bus();

  fp_div_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
    string       name;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: exact quotient with plenty of extra bits, then IEEE rounding
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [3:0] fl, output int lat);
    logic s, za, zb, ia, ib, na, nb;
    longint num, den, qq, rr, rest, half, mant;
    int p, sh, e;
    bit inc;
    s  = a[31] ^ b[31];
    za = (a[30:23] == 8'h00);
    zb = (b[30:23] == 8'h00);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    fl  = 4'd0;
    lat = 1;
    if (na || nb || (za && zb) || (ia && ib)) begin
      res = 32'h7FC00000; fl = 4'b1000;
    end else if (zb && !ia) begin
      res = {s, 31'h7F800000}; fl = 4'b0100;
    end else if (ia) begin
      res = {s, 31'h7F800000};
    end else if (za || ib) begin
      res = {s, 31'd0};
    end else begin
      lat  = NORM_LAT;
      num  = longint'({1'b1, a[22:0]}) <<< 38;
      den  = longint'({1'b1, b[22:0]});
      qq   = num / den;
      rr   = num % den;
      p    = (qq >= (64'sd1 <<< 38)) ? 38 : 37;
      sh   = p - 23;
      mant = qq >>> sh;
      rest = qq & ((64'sd1 <<< sh) - 1);
      half = 64'sd1 <<< (sh - 1);
      e    = int'(a[30:23]) - int'(b[30:23]) + 127 + (p - 38);
      inc  = RNE && ((rest > half) || ((rest == half) && ((rr != 0) || mant[0])));
      mant = mant + longint'(inc);
      if (mant == (64'sd1 <<< 24)) begin
        mant = mant >>> 1;
        e++;
      end
      if (e >= 255) begin
        res = {s, 31'h7F800000}; fl = 4'b0010;
      end else if (e <= 0) begin
        res = {s, 31'd0}; fl = 4'b0001;
      end else begin
        res = {s, 8'(e), 23'(mant)};
      end
    end
  endtask

  // Called #1 after a rising edge with the DUT idle
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [3:0] fl, output int lat);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    fl  = bus.flags;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    int k;
    k = $urandom_range(0, 19);
    if (k == 0)      e = 8'h00;
    else if (k == 1) e = 8'hFF;
    else if (k == 2) e = 8'($urandom_range(1, 20));
    else if (k == 3) e = 8'($urandom_range(235, 254));
    else             e = 8'($urandom_range(1, 254));
    f = 23'($urandom);
    if ($urandom_range(0, 7) == 0) f = 23'd0;
    return {1'($urandom), e, f};
  endfunction

  initial begin
    logic [31:0] res, exp_res, a, b;
    logic [3:0]  fl, exp_fl;
    int          lat, exp_lat, highs;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    bus.result,         32'd0);
    check("rst_flags",     32'(bus.flags),     32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    tbl[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, NORM_LAT, "six_div_two"};
    tbl[1] = '{32'h3F800000, 32'h40400000, RNE ? 32'h3EAAAAAB : 32'h3EAAAAAA, 4'b0000, NORM_LAT, "one_div_three"};
    tbl[2] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1, "one_div_zero"};
    tbl[3] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1, "zero_div_zero"};
    tbl[4] = '{32'hC0000000, 32'h7F800000, 32'h80000000, 4'b0000, 1, "neg_div_inf"};
    tbl[5] = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, NORM_LAT, "overflow"};
    tbl[6] = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, NORM_LAT, "underflow"};

    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].a, tbl[i].b, res, fl, lat);
      check({tbl[i].name, "_result"},  res,       tbl[i].res);
      check({tbl[i].name, "_flags"},   32'(fl),   32'(tbl[i].fl));
      check({tbl[i].name, "_latency"}, 32'(lat),  32'(tbl[i].lat));
      release_result();
    end

    // Backpressure: result held, new operands ignored, in_ready back right after
    do_op(32'h40C00000, 32'h40000000, res, fl, lat);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        bus.a        = 32'h3F800000;
        bus.b        = 32'h40400000;
        bus.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("bp_result",    bus.result,         32'h40400000);
      check("bp_flags",     32'(bus.flags),     32'd0);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    release_result();
    check("bp_ready_after", 32'(bus.in_ready),  32'd1);
    check("bp_valid_after", 32'(bus.out_valid), 32'd0);

    // Reset during iteration 10 of the divide
    bus.a        = 32'h40C00000;
    bus.b        = 32'h40000000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_result",    bus.result,         32'd0);
    check("mid_rst_flags",     32'(bus.flags),     32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    highs = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) highs++;
    end
    check("mid_rst_no_stale", 32'(highs), 32'd0);
    do_op(32'h40C00000, 32'h40000000, res, fl, lat);
    check("post_rst_result",  res,      32'h40400000);
    check("post_rst_flags",   32'(fl),  32'd0);
    check("post_rst_latency", 32'(lat), 32'(NORM_LAT));
    release_result();

    for (int n = 0; n < 300; n++) begin
      a = rnd_op();
      b = rnd_op();
      model(a, b, exp_res, exp_fl, exp_lat);
      do_op(a, b, res, fl, lat);
      check("rand_result",  res,      exp_res);
      check("rand_flags",   32'(fl),  32'(exp_fl));
      check("rand_latency", 32'(lat), 32'(exp_lat));
      release_result();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_div_seq.md
# fp_div_seq

Iterative IEEE-754 single-precision divider for the floating-point ALU. It is the inverse counterpart of the Booth multiplier pipeline. It unpacks two operands and computes the mantissa quotient by restoring division, BITS_PER_CYCLE quotient bits per clock. It then normalises, rounds, repacks and returns the result with exception flags over a valid/ready handshake. It sits beside the multiplier and adder/subtractor stages and shares their unpacked sign/exponent/mantissa conventions.

## Interface
- BITS_PER_CYCLE, 1, quotient bits retired per DIVIDE cycle; legal values 1 or 2.
- clk  input  1  clock, rising edge
- reset  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands present
- in_ready  output  1  high only in IDLE
- a  input  32  dividend, IEEE-754 single
- b  input  32  divisor, IEEE-754 single
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  consumer accepts the result
- result  output  32  quotient
- flags  output  4  {invalid, div_by_zero, overflow, underflow}

## Operation
- States: IDLE, DIVIDE, NORM, DONE.
- Transitions: IDLE→DIVIDE on accept (in_valid & in_ready), or IDLE→DONE on accept when a special case applies; DIVIDE→NORM after the last iteration; NORM→DONE; DONE→IDLE on out_valid & out_ready.
- Unpack:
  - Exponent 0 means zero; denormal inputs are flushed to signed zero.
  - Mantissa ma = {1, frac_a}, 24 bits; mb likewise.
  - Result sign = sa ^ sb.
- Special cases, resolved at accept, in priority order:
  - Either operand NaN, 0/0, or inf/inf → 0x7FC00000, invalid.
  - Finite nonzero / 0 → signed inf, div_by_zero.
  - inf / finite → signed inf, no flag.
  - 0 / nonzero, or finite / inf → signed zero, no flag.
- DIVIDE:
  - Restoring division computes q = floor(ma·2^25 / mb), 26 bits, with remainder r.
  - Partial remainder is 25 bits wide.
  - Iteration counter runs 26/BITS_PER_CYCLE cycles.
- Exponent: e = ea − eb + 127, held as 10-bit signed.
- NORM:
  - If q[25] = 1: mantissa = q[25:2], guard = q[1], sticky = q[0] | (r≠0).
  - Otherwise: mantissa = q[24:1], guard = q[0], sticky = (r≠0), and e − 1.
  - Rounding is applied per Configuration.
  - A rounding carry to 2^24 shifts the mantissa right and increments e.
  - e ≥ 255 → signed inf, overflow.
  - e ≤ 0 → signed zero, underflow (no denormal output).
- DONE: result and flags are stable while out_valid is high and out_ready is low. New inputs are ignored.

## Timing
- Reset values: in_ready = 1 (state IDLE); out_valid = 0; result = 0; flags = 0; counter and datapath registers = 0.
- Latency is counted in clock edges from the accepting edge to the first cycle out_valid is high:
  - Normal path: 26/BITS_PER_CYCLE + 1, i.e. 27 (B=1) or 14 (B=2).
  - Special path: 1.
- Throughput: one operation in flight. in_ready returns high the cycle after the result handshake. No same-cycle accept-after-release.
- in_valid while not in IDLE has no effect. Operands are captured only on the accept edge.
- Reset asserted mid-DIVIDE/NORM/DONE aborts the operation immediately. Outputs go to reset values, and no partial result is ever presented.
- out_ready while out_valid = 0 is ignored.

## Configuration
- FPDIV_ROUND_RNE_EN defined: round to nearest even. Increment when guard & (sticky | mantissa[0]).
- Undefined: truncate (round toward zero). Guard and sticky are discarded, and NORM never carries.
- The macro changes no other timing or port behaviour.

## Structure
- Shared package fp_pkg holds:
  - FP_EXP_BIAS = 127, FP_QNAN = 32'h7FC00000, FP_POS_INF = 32'h7F800000.
  - Flag bit indices.
  - The fpdiv_state_t enum {IDLE, DIVIDE, NORM, DONE}.
- Sub-module fp_div_mant_core: iterative restoring mantissa divider.
  - Interface: start, ma, mb in; q, r, done out.
  - Parameterised by BITS_PER_CYCLE.
- Top level owns unpack, special-case logic, exponent, rounding, packing and the handshake.

## Test plan
- 6.0/2.0: a=0x40C00000, b=0x40000000 → result 0x40400000, flags 0. out_valid exactly 27 edges after accept (14 with BITS_PER_CYCLE=2).
- 1.0/3.0: a=0x3F800000, b=0x40400000 → 0x3EAAAAAB with FPDIV_ROUND_RNE_EN; 0x3EAAAAAA without.
- Special cases, each with latency 1:
  - 1.0/0.0 → 0x7F800000, div_by_zero.
  - 0.0/0.0 → 0x7FC00000, invalid.
  - −2.0/+inf (0xC0000000 / 0x7F800000) → 0x80000000.
- Range limits:
  - 0x7F000000 / 0x3E800000 → 0x7F800000, overflow.
  - 0x00800000 / 0x40000000 → 0x00000000, underflow.
- Backpressure: hold out_ready low 5 cycles after out_valid. result and flags remain stable, in_ready stays 0, and a pulsed in_valid is ignored. After the handshake, in_ready = 1 on the next cycle.
- Reset mid-operation: assert reset at DIVIDE iteration 10. Outputs take reset values immediately. After release, a fresh 6.0/2.0 completes correctly with no stale result.
